// File: rtl/dragon_mover.sv
// Dragon actuator: steps toward the player or sheep, tracks length and reports proximity/capture.
// Optional DRAGON_DIAG_EN: a step may move on both axes at once.
module dragon_mover #(
  parameter int COORD_W     = 4,
  parameter int NEAR_DIST   = 3,
  parameter int MOVE_PERIOD = 8,
  parameter int MAX_LEN     = 7,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [1:0]         dragon_state,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] sheep_x,
  input  logic [COORD_W-1:0] sheep_y,
  input  logic               sheep_valid,
  output logic [COORD_W-1:0] dragon_x,
  output logic [COORD_W-1:0] dragon_y,
  output logic [1:0]         dragon_dir,
  output logic [2:0]         dragon_len,
  output logic               step_pulse,
  output logic               player_near,
  output logic               sheep_near,
  output logic               ate_sheep
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int D_W   = COORD_W + 1;

  localparam logic [1:0] ST_PLAYER = 2'b00;
  localparam logic [1:0] ST_SHEEP  = 2'b01;
  localparam logic [1:0] ST_GROW   = 2'b10;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  function automatic logic [D_W-1:0] abs_d(input logic signed [D_W-1:0] d);
    return d[D_W-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [D_W:0] manhattan(input logic [COORD_W-1:0] ax,
                                             input logic [COORD_W-1:0] ay,
                                             input logic [COORD_W-1:0] bx,
                                             input logic [COORD_W-1:0] by);
    logic signed [D_W-1:0] ddx;
    logic signed [D_W-1:0] ddy;
    ddx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    ddy = $signed({1'b0, ay}) - $signed({1'b0, by});
    return {1'b0, abs_d(ddx)} + {1'b0, abs_d(ddy)};
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'(MAX_LEN)) ? v : v + 3'd1;
  endfunction

  logic [CNT_W-1:0]       cnt;
  logic                   step_req_p0;
  logic                   move_ok;
  logic                   do_step;
  logic                   mv_x;
  logic                   mv_y;
  logic [COORD_W-1:0]     tgt_x;
  logic [COORD_W-1:0]     tgt_y;
  logic [COORD_W-1:0]     nx;
  logic [COORD_W-1:0]     ny;
  logic signed [D_W-1:0]  dx;
  logic signed [D_W-1:0]  dy;
  logic [1:0]             ndir;
  logic [D_W:0]           dist_p;
  logic [D_W:0]           dist_s;
  logic                   lock;
  logic                   prev_grow;
  logic                   grow_rise;
  logic                   same_tile;
  logic                   capture;

  // Stage p0: step request, target selection and next-position decision
  always_comb begin
    step_req_p0 = frame_tick && (cnt == CNT_W'(MOVE_PERIOD - 1));
    tgt_x       = (dragon_state == ST_SHEEP) ? sheep_x : player_x;
    tgt_y       = (dragon_state == ST_SHEEP) ? sheep_y : player_y;
    move_ok     = (dragon_state == ST_SHEEP) ? sheep_valid : (dragon_state != ST_GROW);
    dx          = $signed({1'b0, tgt_x}) - $signed({1'b0, dragon_x});
    dy          = $signed({1'b0, tgt_y}) - $signed({1'b0, dragon_y});
`ifdef DRAGON_DIAG_EN
    mv_x = (dx != '0);
    mv_y = (dy != '0);
`else
    // Larger axis wins; a tie goes to X.
    mv_x = (dx != '0) && (abs_d(dx) >= abs_d(dy));
    mv_y = !mv_x && (dy != '0);
`endif
    nx = dragon_x;
    ny = dragon_y;
    if (mv_x) nx = dx[D_W-1] ? dragon_x - COORD_W'(1) : dragon_x + COORD_W'(1);
    if (mv_y) ny = dy[D_W-1] ? dragon_y - COORD_W'(1) : dragon_y + COORD_W'(1);
    ndir = dragon_dir;
    if (mv_x)      ndir = dx[D_W-1] ? DIR_LEFT : DIR_RIGHT;
    else if (mv_y) ndir = dy[D_W-1] ? DIR_UP : DIR_DOWN;
    do_step = step_req_p0 && move_ok && (mv_x || mv_y);

    dist_p    = manhattan(player_x, player_y, dragon_x, dragon_y);
    dist_s    = manhattan(sheep_x, sheep_y, dragon_x, dragon_y);
    grow_rise = (dragon_state == ST_GROW) && !prev_grow;
    same_tile = sheep_valid && (sheep_x == dragon_x) && (sheep_y == dragon_y);
    capture   = same_tile && (dragon_state == ST_SHEEP) && !lock;
  end

  // Stage p1: registered position, length and feedback flags
  always_ff @(posedge clk) begin
    if (rst) begin
      dragon_x    <= COORD_W'(START_X);
      dragon_y    <= COORD_W'(START_Y);
      dragon_dir  <= DIR_RIGHT;
      dragon_len  <= 3'd1;
      step_pulse  <= 1'b0;
      player_near <= 1'b0;
      sheep_near  <= 1'b0;
      ate_sheep   <= 1'b0;
      cnt         <= '0;
      lock        <= 1'b0;
      prev_grow   <= 1'b0;
    end else begin
      if (frame_tick) cnt <= step_req_p0 ? '0 : cnt + CNT_W'(1);
      step_pulse <= do_step;
      if (do_step) begin
        dragon_x   <= nx;
        dragon_y   <= ny;
        dragon_dir <= ndir;
      end
      prev_grow <= (dragon_state == ST_GROW);
      if (grow_rise) dragon_len <= sat_inc(dragon_len);
      player_near <= (dist_p <= (D_W+1)'(NEAR_DIST));
      sheep_near  <= sheep_valid && (dist_s <= (D_W+1)'(NEAR_DIST));
      ate_sheep   <= capture;
      // Lock holds until the sheep leaves the dragon's tile or disappears.
      if (capture)         lock <= 1'b1;
      else if (!same_tile) lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dragon_mover.sv
// Self-checking bench for dragon_mover: integer reference model plus directed and random stimulus.
module tb_dragon_mover;
  localparam int CW = 4;
  localparam int NEAR = 3;
  localparam int PERIOD = 8;
  localparam int MAXL = 7;

  logic          clk;
  logic          rst;
  logic          frame_tick;
  logic [1:0]    dragon_state;
  logic [CW-1:0] player_x, player_y, sheep_x, sheep_y;
  logic          sheep_valid;
  logic [CW-1:0] dragon_x, dragon_y;
  logic [1:0]    dragon_dir;
  logic [2:0]    dragon_len;
  logic          step_pulse, player_near, sheep_near, ate_sheep;

  dragon_mover #(
    .COORD_W(CW), .NEAR_DIST(NEAR), .MOVE_PERIOD(PERIOD), .MAX_LEN(MAXL),
    .START_X(0), .START_Y(0)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .dragon_state(dragon_state),
    .player_x(player_x), .player_y(player_y), .sheep_x(sheep_x), .sheep_y(sheep_y),
    .sheep_valid(sheep_valid), .dragon_x(dragon_x), .dragon_y(dragon_y),
    .dragon_dir(dragon_dir), .dragon_len(dragon_len), .step_pulse(step_pulse),
    .player_near(player_near), .sheep_near(sheep_near), .ate_sheep(ate_sheep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_steps = 0;
  int n_ate = 0;

  task automatic check(input string name, input int act, input int exp);
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model state, in plain integers
  int mx, my, mdir, mlen, mcnt, mstep, mpn, msn, mate;
  bit mlock, mprev, started;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  always @(posedge clk) begin
    int px, py, sx, sy, st, tx, ty, ddx, ddy;
    bit sv, req, can_move, on_tile;
    px = int'(player_x); py = int'(player_y);
    sx = int'(sheep_x);  sy = int'(sheep_y);
    st = int'(dragon_state); sv = sheep_valid;
    if (rst) begin
      mx = 0; my = 0; mdir = 1; mlen = 1; mcnt = 0;
      mstep = 0; mpn = 0; msn = 0; mate = 0;
      mlock = 0; mprev = 0; started = 1;
    end else if (started) begin
      mpn = (iabs(px - mx) + iabs(py - my) <= NEAR) ? 1 : 0;
      msn = (sv && (iabs(sx - mx) + iabs(sy - my) <= NEAR)) ? 1 : 0;
      on_tile = sv && (sx == mx) && (sy == my);
      mate = (on_tile && st == 1 && !mlock) ? 1 : 0;
      if (mate == 1) mlock = 1;
      else if (!on_tile) mlock = 0;
      if (st == 2 && !mprev && mlen < MAXL) mlen++;
      mprev = (st == 2);
      req = 0;
      if (frame_tick) begin
        mcnt++;
        if (mcnt == PERIOD) begin mcnt = 0; req = 1; end
      end
      mstep = 0;
      can_move = (st == 1) ? sv : (st != 2);
      tx = (st == 1) ? sx : px;
      ty = (st == 1) ? sy : py;
      ddx = tx - mx; ddy = ty - my;
      if (req && can_move && (ddx != 0 || ddy != 0)) begin
        mstep = 1;
`ifdef DRAGON_DIAG_EN
        mx += sgn(ddx); my += sgn(ddy);
        if (ddx != 0) mdir = (ddx > 0) ? 1 : 3;
        else mdir = (ddy > 0) ? 2 : 0;
`else
        if (iabs(ddx) >= iabs(ddy)) begin
          mx += sgn(ddx); mdir = (ddx > 0) ? 1 : 3;
        end else begin
          my += sgn(ddy); mdir = (ddy > 0) ? 2 : 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("dragon_x", int'(dragon_x), mx);
      check("dragon_y", int'(dragon_y), my);
      check("dragon_dir", int'(dragon_dir), mdir);
      check("dragon_len", int'(dragon_len), mlen);
      check("step_pulse", int'(step_pulse), mstep);
      check("player_near", int'(player_near), mpn);
      check("sheep_near", int'(sheep_near), msn);
      check("ate_sheep", int'(ate_sheep), mate);
      if (step_pulse) n_steps++;
      if (ate_sheep) n_ate++;
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(2);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc();
  endtask

  int s0, a0, exp_steps, exp_x, exp_y;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; dragon_state = 2'b00;
    player_x = '0; player_y = '0; sheep_x = '0; sheep_y = '0; sheep_valid = 1'b0;
    cyc(2);
    rst = 1'b0; cyc();
    check("reset_x", int'(dragon_x), 0);
    check("reset_dir", int'(dragon_dir), 1);
    check("reset_len", int'(dragon_len), 1);

    // One step toward player at (5,2)
    player_x = 4'd5; player_y = 4'd2; cyc();
    s0 = n_steps;
    ticks(8); cyc(2);
    check("one_step_count", n_steps - s0, 1);
`ifdef DRAGON_DIAG_EN
    exp_y = 1;
`else
    exp_y = 0;
`endif
    check("one_step_x", int'(dragon_x), 1);
    check("one_step_y", int'(dragon_y), exp_y);
    check("one_step_dir", int'(dragon_dir), 1);

`ifdef DRAGON_DIAG_EN
    do_reset();
    player_x = 4'd2; player_y = 4'd3; cyc();
    ticks(8); cyc(2);
    check("diag_x", int'(dragon_x), 1);
    check("diag_y", int'(dragon_y), 1);
    check("diag_dir", int'(dragon_dir), 1);
`endif

    // Tie-break walk to (3,3)
    do_reset();
    player_x = 4'd3; player_y = 4'd3; cyc();
    s0 = n_steps;
    ticks(48); cyc(2);
`ifdef DRAGON_DIAG_EN
    exp_steps = 3;
`else
    exp_steps = 6;
`endif
    check("walk_steps", n_steps - s0, exp_steps);
    check("walk_x", int'(dragon_x), 3);
    check("walk_y", int'(dragon_y), 3);
    check("walk_near", int'(player_near), 1);
    s0 = n_steps;
    ticks(16); cyc(2);
    check("walk_no_more", n_steps - s0, 0);

    // Sheep capture and re-arm
    do_reset();
    dragon_state = 2'b01; sheep_valid = 1'b1; sheep_x = 4'd2; sheep_y = 4'd0;
    player_x = 4'd12; player_y = 4'd12; cyc();
    a0 = n_ate;
    ticks(16); cyc(3);
    check("sheep_x", int'(dragon_x), 2);
    check("sheep_y", int'(dragon_y), 0);
    check("ate_once", n_ate - a0, 1);
    cyc(100);
    check("ate_hold", n_ate - a0, 1);
    sheep_x = 4'd9; sheep_y = 4'd9; cyc(3);
    sheep_x = 4'd2; sheep_y = 4'd0; cyc(3);
    check("ate_rearm", n_ate - a0, 2);

    // Growth to saturation, with ticks running
    do_reset();
    dragon_state = 2'b00; sheep_valid = 1'b0; player_x = 4'd8; player_y = 4'd6;
    for (int k = 0; k < 8; k++) begin
      dragon_state = 2'b00; frame_tick = 1'b1; cyc(2);
      dragon_state = 2'b10; cyc(2);
    end
    frame_tick = 1'b0; dragon_state = 2'b00; cyc(2);
    check("len_sat", int'(dragon_len), 7);

    // Reset coinciding with a wrapping tick
    do_reset();
    player_x = 4'd4; player_y = 4'd4; cyc();
    ticks(64); cyc(2);
    check("pre_rst_x", int'(dragon_x), 4);
    check("pre_rst_y", int'(dragon_y), 4);
    player_x = 4'd9; player_y = 4'd9;
    ticks(7);
    frame_tick = 1'b1; rst = 1'b1; cyc();
    frame_tick = 1'b0; rst = 1'b0;
    check("rst_x", int'(dragon_x), 0);
    check("rst_y", int'(dragon_y), 0);
    check("rst_len", int'(dragon_len), 1);
    check("rst_step", int'(step_pulse), 0);
    check("rst_near", int'(player_near), 0);
    s0 = n_steps;
    ticks(7); cyc(2);
    check("rst_cnt_7", n_steps - s0, 0);
    ticks(1); cyc(2);
    check("rst_cnt_8", n_steps - s0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) dragon_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) begin
        player_x = 4'($urandom_range(0, 15)); player_y = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 30) == 0) begin
        sheep_x = ($urandom_range(0, 1) == 0) ? dragon_x : 4'($urandom_range(0, 15));
        sheep_y = ($urandom_range(0, 1) == 0) ? dragon_y : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 50) == 0) sheep_valid = ~sheep_valid;
      rst = ($urandom_range(0, 400) == 0);
      cyc();
    end
    rst = 1'b0; frame_tick = 1'b0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
